// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operation codes and controller states.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_op_t;

   // Operation class requested by the FSM; FUNCT defers to the funct field.
   typedef enum logic [1:0] {
      AOP_ADD   = 2'd0,
      AOP_SUB   = 2'd1,
      AOP_FUNCT = 2'd2
   } alu_class_t;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } ctrl_state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class and the funct field to the ALU control
// code; funct_bad_o flags a funct outside the supported R-type set.
module alu_decoder
   import mips_pkg::*;
(
   input  alu_class_t  alu_class_i,
   input  logic [5:0]  funct_i,
   output alu_op_t     alu_control_o,
   output logic        funct_bad_o
);

   alu_op_t funct_op;

   always_comb begin
      funct_op    = ALU_ADD;
      funct_bad_o = 1'b0;
      case (funct_i)
         FN_ADD:  funct_op = ALU_ADD;
         FN_SUB:  funct_op = ALU_SUB;
         FN_AND:  funct_op = ALU_AND;
         FN_OR:   funct_op = ALU_OR;
         FN_NOR:  funct_op = ALU_NOR;
         FN_SLT:  funct_op = ALU_SLT;
         default: funct_bad_o = 1'b1;
      endcase
   end

   always_comb begin
      case (alu_class_i)
         AOP_SUB:   alu_control_o = ALU_SUB;
         AOP_FUNCT: alu_control_o = funct_op;
         default:   alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences each
// instruction and drives every datapath select, write enable and ALU code.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on memReady
// DECODE   | compute branch target, dispatch on op
// MEMADR   | ALUOut <= A + sign-extended imm
// MEMREAD  | load from ALUOut, wait for memReady
// MEMWB    | rt <= memory data
// MEMWRITE | store to ALUOut, wait for memReady
// EXECUTE  | R-type ALU operation
// ALUWB    | rd <= ALUOut
// BRANCH   | compare A-B, load PC with target if zero
// ADDIEXEC | A + sign-extended imm
// ADDIWB   | rt <= ALUOut
// JUMP     | PC <= jump target
module multicycle_controller
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memReady,
   output logic       memReq,
   output logic       memWrite,
   output logic       iorD,
   output logic       irWrite,
   output logic       regDst,
   output logic       memtoReg,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [2:0] aluControl,
   output logic [1:0] pcSrc,
   output logic       pcEn,
   output logic       retired,
   output logic       illegalOp
);

   ctrl_state_t state_q, state_d;
   alu_class_t  alu_class;
   alu_op_t     alu_op;
   logic        funct_bad;
   logic        pc_write;
   logic        branch;

   alu_decoder u_alu_decoder (
      .alu_class_i   (alu_class),
      .funct_i       (funct),
      .alu_control_o (alu_op),
      .funct_bad_o   (funct_bad)
   );

   assign aluControl = alu_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      alu_class = AOP_ADD;
      memReq    = 1'b0;
      memWrite  = 1'b0;
      iorD      = 1'b0;
      irWrite   = 1'b0;
      regDst    = 1'b0;
      memtoReg  = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      pcSrc     = 2'b00;
      pc_write  = 1'b0;
      branch    = 1'b0;
      retired   = 1'b0;
      illegalOp = 1'b0;
      case (state_q)
         FETCH: begin
            memReq  = 1'b1;
            aluSrcB = 2'b01;
            if (memReady) begin
               irWrite  = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            aluSrcB = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = funct_bad ? FETCH : EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
            if (state_d == FETCH) begin
               illegalOp = 1'b1;
               retired   = 1'b1;
            end
         end
         MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            memReq = 1'b1;
            iorD   = 1'b1;
            if (memReady) state_d = MEMWB;
         end
         MEMWB: begin
            memtoReg = 1'b1;
            regWrite = 1'b1;
            retired  = 1'b1;
            state_d  = FETCH;
         end
         MEMWRITE: begin
            memReq   = 1'b1;
            iorD     = 1'b1;
            memWrite = 1'b1;
            if (memReady) begin
               retired = 1'b1;
               state_d = FETCH;
            end
         end
         EXECUTE: begin
            aluSrcA   = 1'b1;
            alu_class = AOP_FUNCT;
            state_d   = ALUWB;
         end
         ALUWB: begin
            regDst   = 1'b1;
            regWrite = 1'b1;
            retired  = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            aluSrcA   = 1'b1;
            alu_class = AOP_SUB;
            pcSrc     = 2'b01;
            branch    = 1'b1;
            retired   = 1'b1;
            state_d   = FETCH;
         end
         ADDIEXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: begin
            regWrite = 1'b1;
            retired  = 1'b1;
            state_d  = FETCH;
         end
         JUMP: begin
            pcSrc    = 2'b10;
            pc_write = 1'b1;
            retired  = 1'b1;
            state_d  = FETCH;
         end
         default: state_d = FETCH;
      endcase
      // Strobes are masked while reset is high so an aborted access or write
      // never completes in the cycle reset arrives.
      if (reset) begin
         memReq    = 1'b0;
         memWrite  = 1'b0;
         irWrite   = 1'b0;
         regWrite  = 1'b0;
         pc_write  = 1'b0;
         branch    = 1'b0;
         retired   = 1'b0;
         illegalOp = 1'b0;
      end
      pcEn = pc_write | (branch & zero);
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memReady;
   logic       memReq, memWrite, iorD, irWrite, regDst, memtoReg, regWrite;
   logic       aluSrcA, pcEn, retired, illegalOp;
   logic [1:0] aluSrcB, pcSrc;
   logic [2:0] aluControl;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc;

   logic [5:0] seq_op  [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
   int         seq_len [6] = '{5, 4, 4, 4, 3, 3};
   logic       seq_wr  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   int         seq_ret [6] = '{5, 9, 13, 17, 20, 23};
   logic [5:0] fn_tab  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .memReady   (memReady),
      .memReq     (memReq),
      .memWrite   (memWrite),
      .iorD       (iorD),
      .irWrite    (irWrite),
      .regDst     (regDst),
      .memtoReg   (memtoReg),
      .regWrite   (regWrite),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .aluControl (aluControl),
      .pcSrc      (pcSrc),
      .pcEn       (pcEn),
      .retired    (retired),
      .illegalOp  (illegalOp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      reset = 1'b1; memReady = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
      #2;
      check("rst_memReq",  memReq, 0);
      check("rst_irWrite", irWrite, 0);
      check("rst_pcEn",    pcEn, 0);
      check("rst_retired", retired, 0);
      check("rst_aluSrcB", aluSrcB, 2'b01);
      check("rst_aluCtl",  aluControl, 0);
      tick;
      check("rst_hold_memReq", memReq, 0);
      reset = 1'b0;
      cyc = 1;
      #1;
      check("first_fetch_memReq", memReq, 1);

      // Back-to-back lw, sw, add, addi, beq (not taken), j.
      for (int i = 0; i < 6; i++) begin
         op = seq_op[i];
         funct = 6'h20;
         for (int k = 1; k <= seq_len[i]; k++) begin
            #1;
            if (k == seq_len[i]) begin
               check("seq_retired", retired, 1);
               check("seq_retire_cycle", cyc, seq_ret[i]);
               check("seq_regWrite_last", regWrite, seq_wr[i]);
               if (op == 6'h04) check("beq_nt_pcEn", pcEn, 0);
            end else begin
               check("seq_no_retired", retired, 0);
               check("seq_no_regWrite", regWrite, 0);
            end
            tick;
         end
      end

      // R-type ALU control for each supported funct.
      for (int i = 0; i < 6; i++) begin
         op = 6'h00;
         funct = fn_tab[i];
         #1; check("rt_fetch_memReq", memReq, 1);
         tick; #1; check("rt_decode_illegal", illegalOp, 0);
         tick; #1;
         check("rt_exec_aluControl", aluControl, i);
         check("rt_exec_aluSrcA", aluSrcA, 1);
         check("rt_exec_aluSrcB", aluSrcB, 0);
         tick; #1;
         check("rt_wb_regDst", regDst, 1);
         check("rt_wb_regWrite", regWrite, 1);
         tick;
      end

      // Unsupported funct and unsupported op.
      op = 6'h00; funct = 6'h03;
      tick; #1;
      check("badfn_illegal", illegalOp, 1);
      check("badfn_retired", retired, 1);
      check("badfn_regWrite", regWrite, 0);
      tick; #1;
      check("badfn_back_fetch", memReq, 1);
      check("badfn_pulse_end", illegalOp, 0);
      op = 6'h3F; funct = 6'h20;
      tick; #1;
      check("badop_illegal", illegalOp, 1);
      tick;

      // beq taken; pcEn tracks zero within the cycle.
      op = 6'h04;
      tick; tick;
      zero = 1'b1; #1;
      check("beq_t_pcEn", pcEn, 1);
      check("beq_t_pcSrc", pcSrc, 2'b01);
      check("beq_t_aluControl", aluControl, 1);
      zero = 1'b0; #1;
      check("beq_zero_drop_pcEn", pcEn, 0);
      tick;

      // FETCH stall then jump.
      op = 6'h02; memReady = 1'b0; #1;
      check("fstall_irWrite", irWrite, 0);
      check("fstall_pcEn", pcEn, 0);
      tick; #1;
      check("fstall_hold_memReq", memReq, 1);
      memReady = 1'b1; #1;
      check("fetch_irWrite", irWrite, 1);
      check("fetch_pcEn", pcEn, 1);
      tick; #1;
      check("decode_aluSrcB", aluSrcB, 2'b11);
      tick; #1;
      check("j_pcSrc", pcSrc, 2'b10);
      check("j_pcEn", pcEn, 1);
      check("j_retired", retired, 1);
      tick;

      // lw with three wait cycles in MEMREAD.
      op = 6'h23; start_cyc = cyc;
      tick; tick; #1;
      check("lw_memadr_aluSrcB", aluSrcB, 2'b10);
      tick;
      memReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("lw_wait_memReq", memReq, 1);
         check("lw_wait_iorD", iorD, 1);
         check("lw_wait_retired", retired, 0);
         tick;
      end
      memReady = 1'b1; #1;
      check("lw_done_memReq", memReq, 1);
      tick; #1;
      check("lw_wb_memtoReg", memtoReg, 1);
      check("lw_wb_regWrite", regWrite, 1);
      check("lw_wb_retired", retired, 1);
      check("lw_total_cycles", cyc - start_cyc + 1, 8);
      tick;

      // Reset during a stalled store.
      op = 6'h2B;
      tick; tick; tick;
      memReady = 1'b0; #1;
      check("sw_wait_memWrite", memWrite, 1);
      tick; #1;
      check("sw_wait2_memWrite", memWrite, 1);
      reset = 1'b1; #1;
      check("sw_rst_memWrite", memWrite, 0);
      check("sw_rst_memReq", memReq, 0);
      tick; #1;
      check("sw_rst_hold_memReq", memReq, 0);
      reset = 1'b0; #1;
      check("post_rst_memReq", memReq, 1);
      check("post_rst_memWrite", memWrite, 0);
      check("post_rst_iorD", iorD, 0);
      check("post_rst_retired", retired, 0);
      tick; #1;
      check("post_rst_fetch_hold", memReq, 1);
      check("post_rst_no_retired", retired, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle MIPS datapath. Decodes the instruction register fields, sequences each instruction through fetch/decode/execute/memory/writeback cycles, drives all datapath mux selects and write enables, and generates the 3-bit ALU operation code. It sits beside the datapath and is the only block that drives the ALU control input.

## Interface
- No parameters. Datapath width is fixed at 32 bits, opcode and funct at 6 bits.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory handshake; access completes in a cycle with memReq=1 and memReady=1.
- memReq  out  1  memory access request.
- memWrite  out  1  memory write strobe.
- iorD  out  1  address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  instruction register load.
- regDst  out  1  write register select: 0 = rt, 1 = rd.
- memtoReg  out  1  write data select: 0 = ALUOut, 1 = memory data.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0 = PC, 1 = register A.
- aluSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- aluControl  out  3  0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt.
- pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcEn  out  1  PC load = pcWrite | (branch & zero).
- retired  out  1  one-cycle pulse in the final cycle of each instruction.
- illegalOp  out  1  one-cycle pulse in DECODE for an unsupported op or funct.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP. All outputs are decoded from the state register plus the zero, memReady, op and funct inputs. Every output not listed for a state is 0.
- FETCH: memReq=1, aluSrcB=01, aluControl=add. irWrite=pcWrite=1 only when memReady=1. Moves to DECODE on memReady, otherwise holds.
- DECODE: aluSrcB=11, aluControl=add. Next state by op:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> EXECUTE
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEXEC
  - 0x02 -> JUMP
  - any other op, or op 0x00 with an unsupported funct -> illegalOp=1, retired=1, next FETCH.
- MEMADR: aluSrcA=1, aluSrcB=10, add. Goes to MEMREAD for 0x23, MEMWRITE for 0x2B.
- MEMREAD: memReq=1, iorD=1. Holds until memReady, then goes to MEMWB.
- MEMWB: memtoReg=1, regWrite=1, retired=1.
- MEMWRITE: memReq=1, iorD=1, memWrite=1. Holds until memReady; retired=1 in the completing cycle.
- EXECUTE: aluSrcA=1, aluSrcB=00. aluControl by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
- ALUWB: regDst=1, regWrite=1, retired=1.
- BRANCH: aluSrcA=1, aluControl=sub, pcSrc=01, branch=1, retired=1.
- ADDIEXEC: aluSrcA=1, aluSrcB=10, add. ADDIWB: regWrite=1, retired=1.
- JUMP: pcSrc=10, pcWrite=1, retired=1.
- Every terminal state returns to FETCH.

## Timing
- Cycles per instruction with memReady held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- While reset is high: state=FETCH, and memReq, memWrite, irWrite, regWrite, pcEn, retired and illegalOp are all 0; mux selects take their FETCH values. The first fetch request occurs in the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts the instruction immediately, with no partial write in that cycle.
- memReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- pcEn in BRANCH follows zero combinationally within the same cycle.

## Structure
- Shared package mips_pkg holds:
  - opcode and funct localparams
  - alu_op_t enum (ADD=0 … SLT=5)
  - ctrl_state_t enum.
- Sub-module alu_decoder maps (aluOp class, funct) to aluControl and flags an unsupported funct.

## Test plan
- memReady=1; sequence lw, sw, R-add, addi, beq, j -> retired pulses at cycles 5, 9, 13, 17, 20, 23; regWrite asserted only in MEMWB, ALUWB and ADDIWB.
- R-type with funct 0x20/0x22/0x24/0x25/0x27/0x2A -> aluControl 0/1/2/3/4/5 in EXECUTE. Funct 0x03 -> illegalOp pulse in DECODE, then FETCH, with no regWrite.
- beq with zero=1 -> pcEn=1 and pcSrc=01 in BRANCH. With zero=0 -> pcEn=0.
- lw with memReady low for 3 cycles in MEMREAD -> memReq and iorD held for 4 cycles, MEMWB on the cycle after memReady rises, lw total 8 cycles.
- Reset asserted in MEMWRITE mid-wait -> memWrite drops in the same cycle. After release, FETCH with memReq=1 and no retired pulse.
